// File: rtl/tick_timer_sched.sv
// Shares one base-rate tick among NUM_CH programmable timers.
// Each channel supports one-shot or periodic mode and emits a 1-cycle expire strobe.
module tick_timer_sched #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] cancel,
  input  logic [NUM_CH-1:0] periodic,
  output logic [NUM_CH-1:0] expire,
  output logic [NUM_CH-1:0] busy,
  output logic              start_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q  [NUM_CH];
  state_e             state_d  [NUM_CH];
  logic [CNT_W-1:0]   cnt_q    [NUM_CH];
  logic [CNT_W-1:0]   cnt_d    [NUM_CH];
  logic [CNT_W-1:0]   period_q [NUM_CH];
  logic [CNT_W-1:0]   period_d [NUM_CH];
  logic [NUM_CH-1:0]  mode_q, mode_d;
  logic [NUM_CH-1:0]  expire_q, expire_d;
  logic               start_err_q, start_err_d;

  // Period writes only take effect on the next edge, so a same-cycle start
  // deliberately sees the old period_q value.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      period_d[i] = period_q[i];
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        period_d[i] = cfg_period;
      end
    end
  end

  // Per-channel priority: cancel over start over tick.
  always_comb begin
    start_err_d = 1'b0;
    expire_d    = '0;
    mode_d      = mode_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (cancel[i]) begin
        state_d[i] = IDLE;
      end else if (start[i]) begin
        if (period_q[i] != '0) begin
          state_d[i] = RUN;
          cnt_d[i]   = period_q[i];
          mode_d[i]  = periodic[i];
        end else begin
          state_d[i]  = IDLE;
          start_err_d = 1'b1;
        end
      end else if ((state_q[i] == RUN) && tick) begin
        if (cnt_q[i] > CNT_W'(1)) begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end else begin
          expire_d[i] = 1'b1;
          if (mode_q[i] && (period_q[i] != '0)) begin
            cnt_d[i] = period_q[i];
          end else begin
            state_d[i] = IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= IDLE;
        cnt_q[i]    <= '0;
        period_q[i] <= '0;
      end
      mode_q      <= '0;
      expire_q    <= '0;
      start_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        period_q[i] <= period_d[i];
      end
      mode_q      <= mode_d;
      expire_q    <= expire_d;
      start_err_q <= start_err_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      busy[i] = (state_q[i] == RUN);
    end
  end

  assign expire    = expire_q;
  assign start_err = start_err_q;

endmodule
